// File: rtl/cla_pkg.sv
// rtl/cla_pkg.sv - width and grouping constants for the 16-bit carry-lookahead adder
package cla_pkg;

  localparam int CLA_WIDTH   = 16;
  localparam int CLA_GROUP   = 4;
  localparam int CLA_NGROUPS = CLA_WIDTH / CLA_GROUP;

  typedef logic [CLA_WIDTH-1:0] cla_word_t;
  typedef logic [CLA_GROUP-1:0] cla_nibble_t;

endpackage

// File: rtl/cla_block4.sv
// rtl/cla_block4.sv - 4-bit lookahead group: sum bits plus group generate/propagate
module cla_block4
  import cla_pkg::*;
(
  input  logic [CLA_GROUP-1:0] a,
  input  logic [CLA_GROUP-1:0] b,
  input  logic                 cin,
  output logic [CLA_GROUP-1:0] s,
  output logic                 group_g,
  output logic                 group_p
);

  logic [CLA_GROUP-1:0] g;
  logic [CLA_GROUP-1:0] p;
  logic [CLA_GROUP-1:0] c;

  assign g = a & b;
  assign p = a ^ b;

  // Every internal carry is a flat sum of products off cin, so no bit waits on its neighbour.
  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);

  assign s = p ^ c;

  assign group_g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  assign group_p = &p;

endmodule

// File: rtl/cla_adder_16.sv
// rtl/cla_adder_16.sv - 16-bit two-level carry-lookahead adder with registered sum and carry out
module cla_adder_16
  import cla_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  output logic [CLA_WIDTH-1:0] sum,
  output logic                 carry_out,
  input  logic [CLA_WIDTH-1:0] a,
  input  logic [CLA_WIDTH-1:0] b,
  input  logic                 carry_in
);

  logic [CLA_NGROUPS-1:0] grp_g;
  logic [CLA_NGROUPS-1:0] grp_p;
  logic [CLA_NGROUPS:0]   grp_c;
  logic [CLA_WIDTH-1:0]   sum_d;
  logic [CLA_WIDTH-1:0]   sum_q;
  logic                   carry_d;
  logic                   carry_q;

  // Second-level lookahead: each group carry derives directly from carry_in and group G/P.
  assign grp_c[0] = carry_in;
  assign grp_c[1] = grp_g[0] | (grp_p[0] & carry_in);
  assign grp_c[2] = grp_g[1] | (grp_p[1] & grp_g[0]) | (grp_p[1] & grp_p[0] & carry_in);
  assign grp_c[3] = grp_g[2] | (grp_p[2] & grp_g[1]) | (grp_p[2] & grp_p[1] & grp_g[0])
                  | (grp_p[2] & grp_p[1] & grp_p[0] & carry_in);
  assign grp_c[4] = grp_g[3] | (grp_p[3] & grp_g[2]) | (grp_p[3] & grp_p[2] & grp_g[1])
                  | (grp_p[3] & grp_p[2] & grp_p[1] & grp_g[0])
                  | (grp_p[3] & grp_p[2] & grp_p[1] & grp_p[0] & carry_in);

  for (genvar gi = 0; gi < CLA_NGROUPS; gi++) begin : g_blk
    cla_block4 u_blk (
      .a       (a[gi*CLA_GROUP +: CLA_GROUP]),
      .b       (b[gi*CLA_GROUP +: CLA_GROUP]),
      .cin     (grp_c[gi]),
      .s       (sum_d[gi*CLA_GROUP +: CLA_GROUP]),
      .group_g (grp_g[gi]),
      .group_p (grp_p[gi])
    );
  end

  assign carry_d = grp_c[CLA_NGROUPS];

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      sum_q   <= sum_d;
      carry_q <= carry_d;
    end
  end

  assign sum       = sum_q;
  assign carry_out = carry_q;

endmodule

// File: tb/tb_cla_adder_16.sv
// tb/tb_cla_adder_16.sv - self-checking bench for cla_adder_16
module tb_cla_adder_16;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] sum;
  logic        carry_out;
  logic [15:0] a;
  logic [15:0] b;
  logic        carry_in;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  cla_adder_16 dut (
    .clk       (clk),
    .rst       (rst),
    .sum       (sum),
    .carry_out (carry_out),
    .a         (a),
    .b         (b),
    .carry_in  (carry_in)
  );

  task automatic check(input string tag, input logic [16:0] obs, input logic [16:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Apply one vector, clock it in, then compare just after the edge against a fixed answer.
  task automatic stepx(input string tag, input logic r, input logic [15:0] av,
                       input logic [15:0] bv, input logic ci, input logic [16:0] exp);
    rst = r; a = av; b = bv; carry_in = ci;
    @(posedge clk);
    #1;
    check(tag, {carry_out, sum}, exp);
  endtask

  // Same, but the answer comes from plain 17-bit arithmetic.
  task automatic stepm(input string tag, input logic r, input logic [15:0] av,
                       input logic [15:0] bv, input logic ci);
    logic [16:0] exp;
    exp = r ? 17'd0 : (17'(av) + 17'(bv) + 17'(ci));
    stepx(tag, r, av, bv, ci, exp);
  endtask

  initial begin
    logic [15:0] ra;
    logic [15:0] rb;
    logic        rc;
    logic [16:0] held;

    stepx("reset_edge1", 1'b1, 16'd7, 16'd7, 1'b0, 17'd0);
    stepx("reset_edge2", 1'b1, 16'd7, 16'd7, 1'b0, 17'd0);
    stepx("reset_release", 1'b0, 16'd7, 16'd7, 1'b0, 17'd14);

    stepx("small_1p1", 1'b0, 16'd1, 16'd1, 1'b0, 17'd2);
    stepx("small_2p2", 1'b0, 16'd2, 16'd2, 1'b0, 17'd4);
    stepx("small_125", 1'b0, 16'd125, 16'd125, 1'b0, 17'd250);

    stepx("mid_2000", 1'b0, 16'd2000, 16'd2000, 1'b0, 17'd4000);
    stepx("mid_1000", 1'b0, 16'd1000, 16'd1000, 1'b0, 17'd2000);
    stepx("mid_30000", 1'b0, 16'd30000, 16'd30000, 1'b0, 17'd60000);

    stepx("cin_zero", 1'b0, 16'h0000, 16'h0000, 1'b1, 17'h00001);
    stepx("wrap_ffff_1", 1'b0, 16'hFFFF, 16'h0001, 1'b0, 17'h10000);
    stepx("wrap_ffff_ffff_c", 1'b0, 16'hFFFF, 16'hFFFF, 1'b1, 17'h1FFFF);
    stepx("wrap_8000", 1'b0, 16'h8000, 16'h8000, 1'b0, 17'h10000);

    stepx("grp_0fff", 1'b0, 16'h0FFF, 16'h0001, 1'b0, 17'h01000);
    stepx("grp_00ff", 1'b0, 16'h00FF, 16'h0001, 1'b0, 17'h00100);
    stepx("grp_000f", 1'b0, 16'h000F, 16'h0001, 1'b0, 17'h00010);
    stepx("grp_7fff", 1'b0, 16'h7FFF, 16'h0001, 1'b0, 17'h08000);

    // Outputs must hold while inputs move between edges.
    held = {carry_out, sum};
    a = 16'hFFFF; b = 16'hFFFF; carry_in = 1'b1;
    #3;
    check("hold_between_edges", {carry_out, sum}, 17'h08000);
    check("hold_matches_prev", {carry_out, sum}, held);

    for (int i = 0; i < 10000; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom);
      if (i == 5000) stepm("rand_rst_inflight", 1'b1, ra, rb, rc);
      else if (i == 5001) stepm("rand_after_rst", 1'b0, ra, rb, rc);
      else stepm("rand", 1'b0, ra, rb, rc);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cla_adder_16.md
Name: cla_adder_16

Overview:
- 16-bit two's-complement/unsigned carry-lookahead adder with carry-in and carry-out.
- Four 4-bit lookahead groups feed a second-level lookahead unit that produces the group carries.
- Inputs are combinational; sum and carry_out are registered on the rising clock edge.
- Used as the arithmetic core wherever a fast 16-bit add is needed in the datapath.

Parameters:
- None. Width is fixed at 16 bits and group size at 4 bits; both come from package constants.

Ports:
- clk  input  1  system clock, rising-edge active
- rst  input  1  synchronous reset, active-high
- sum  output  16  registered sum bits [15:0]
- carry_out  output  1  registered carry out of bit 15
- a  input  16  operand A
- b  input  16  operand B
- carry_in  input  1  carry into bit 0
- Port declaration order is exactly as listed above. Instantiate by name.

Behaviour:
- Single clock (clk). Reset is synchronous and active-high (rst). There is no asynchronous path.
- Reset: on a rising clk edge with rst=1, sum<=16'd0 and carry_out<=0, regardless of a, b or carry_in.
- Normal operation, on each rising clk edge with rst=0: {carry_out,sum} <= a + b + carry_in, computed as a 17-bit result with no saturation.
- Latency is exactly 1 cycle. New operands can be applied every cycle (throughput 1/cycle). There is no handshake.
- Reset mid-operation: rst wins on that edge. The first valid result appears on the first edge after rst is released.
- Carry logic:
  - Per bit: g_i = a_i & b_i, p_i = a_i ^ b_i, sum_i = p_i ^ c_i.
  - Group level (4 bits): group generate G = g3 | p3g2 | p3p2g1 | p3p2p1g0; group propagate P = p3p2p1p0. Internal carries are in flattened lookahead form, not ripple.
  - Second level: C4, C8, C12, C16 come from the G/P of each group and carry_in, also flattened. carry_out = C16.
- No ripple chain is allowed across group boundaries.
- Wrap-around: 0xFFFF + 0x0001 + 0 gives sum=0x0000, carry_out=1. 0xFFFF + 0xFFFF + 1 gives sum=0xFFFF, carry_out=1.
- carry_in=1 with a=b=0 gives sum=1, carry_out=0.
- Outputs hold their value between edges. Input changes between edges have no effect until the next edge.
- No X on outputs after the first reset edge, provided the inputs are known.

Decomposition:
- Package cla_pkg holds:
  - CLA_WIDTH = 16
  - CLA_GROUP = 4
  - CLA_NGROUPS = CLA_WIDTH / CLA_GROUP
- Sub-module cla_block4 (combinational): inputs a[3:0], b[3:0], cin; outputs s[3:0], group_g, group_p. It is instantiated 4 times.
- The second-level lookahead carry logic and the output register live in the top module cla_adder_16.

Test Plan:
- Reset check: hold rst=1 with a=7, b=7 for 2 edges -> sum=0, carry_out=0. Release rst -> on the next edge sum=14, carry_out=0.
- Directed small values, one per cycle:
  - 1+1 -> 2
  - 2+2 -> 4
  - 125+125 -> 250
  - Each appears one cycle after it is applied, with carry_out=0.
- Mid-range values:
  - 2000+2000 -> 4000
  - 1000+1000 -> 2000
  - 30000+30000 -> 60000, with carry_out=0 in all three cases.
- Carry-in and boundaries:
  - 0+0 with carry_in=1 -> 1
  - 0xFFFF+0x0001 with carry_in=0 -> sum=0, carry_out=1
  - 0xFFFF+0xFFFF with carry_in=1 -> sum=0xFFFF, carry_out=1
  - 0x8000+0x8000 -> sum=0, carry_out=1
- Group-boundary propagation:
  - 0x0FFF+0x0001 -> 0x1000
  - 0x00FF+0x0001 -> 0x0100
  - 0x000F+0x0001 -> 0x0010
  - 0x7FFF+0x0001 -> 0x8000, with carry_out=0 in all four cases.
- Random plus reset-in-flight:
  - Apply 10k random {a, b, carry_in} vectors and compare against a 17-bit golden model with 1-cycle delay.
  - Assert rst for one cycle mid-stream -> that cycle's output is 0, and the next vector's result is correct.
